cic_interp_n: RTL and testbench

//  Parametrised N-stage CIC interpolator with input handshake; replaces the fixed 3-comb/3-integrator chain.

---
 rtl/cic_pkg.sv | 27 ++
 rtl/cic_integrator_stage.sv | 29 ++
 rtl/cic_interp_n.sv | 158 +++++++++++++++
 tb/tb_cic_interp_n.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Elaboration helpers shared by the CIC interpolator: log2, power-of-two test and accumulator width.
package cic_pkg;

    localparam int CIC_MIN_STAGES = 1;
    localparam int CIC_MAX_STAGES = 6;
    localparam int CIC_MIN_RATE   = 2;
    localparam int CIC_MAX_RATE   = 4096;

    function automatic int f_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic bit f_is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Bit growth of an N-stage CIC is N*log2(R) on top of the input width.
    function automatic int f_acc_w(input int in_w, input int stages, input int rate);
        return in_w + stages * f_log2(rate);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: wrap-around accumulator that adds its input on every output-rate strobe.
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int ACC_W = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [ACC_W-1:0] acc_out
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (ena) acc_d = acc_q + acc_in;
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_out = acc_q;

endmodule

// File: rtl/cic_interp_n.sv
// N-stage CIC interpolator with 1-entry input buffer, underrun flag and unity DC gain.
// Optional CIC_UNSIGNED_OUT_EN: out_sample is offset binary (MSB inverted) for direct DAC drive.
module cic_interp_n
    import cic_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int STAGES = 3,
    parameter int RATE   = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out_ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sample,
    output logic [OUT_W-1:0] out_sample,
    output logic             out_valid,
    output logic             underrun
);

    localparam int LR      = f_log2(RATE);
    localparam int ACC_W   = f_acc_w(IN_W, STAGES, RATE);
    localparam int SHIFT   = (STAGES - 1) * LR;
    localparam int DROP    = IN_W - OUT_W;
    localparam int DROP_M1 = (DROP > 0) ? DROP - 1 : 0;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t HALF    = (DROP > 0) ? (acc_t'(1) << DROP_M1) : '0;
    localparam acc_t OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

`ifdef CIC_UNSIGNED_OUT_EN
    localparam logic [OUT_W-1:0] OUT_RST = {1'b1, {(OUT_W-1){1'b0}}};
`else
    localparam logic [OUT_W-1:0] OUT_RST = '0;
`endif

    if (!f_is_pow2(RATE) || RATE < CIC_MIN_RATE || RATE > CIC_MAX_RATE ||
        STAGES < CIC_MIN_STAGES || STAGES > CIC_MAX_STAGES || OUT_W > IN_W) begin : g_param_check
        $error("cic_interp_n: unsupported RATE/STAGES/OUT_W combination");
    end

    // Round half up to OUT_W; only the positive side can overflow after adding the half LSB.
    function automatic logic [OUT_W-1:0] f_round(input acc_t value);
        acc_t rounded;
        rounded = (value + HALF) >>> DROP;
        if (rounded > OUT_MAX) rounded = OUT_MAX;
        return rounded[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] f_format(input logic [OUT_W-1:0] value);
`ifdef CIC_UNSIGNED_OUT_EN
        return {~value[OUT_W-1], value[OUT_W-2:0]};
`else
        return value;
`endif
    endfunction

    logic [LR-1:0]          phase_q, phase_d;
    logic                   buf_full_q, buf_full_d;
    logic                   in_ready_q, in_ready_d;
    logic                   underrun_q, underrun_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [IN_W-1:0] buf_q, buf_d;
    logic signed [IN_W-1:0] last_q, last_d;
    logic signed [IN_W-1:0] eff_sample;
    logic [OUT_W-1:0]       out_q, out_d;
    logic                   tick;
    logic                   accept;

    acc_t comb_val   [STAGES+1];
    acc_t comb_dly_q [STAGES];
    acc_t comb_dly_d [STAGES];
    acc_t integ_in   [STAGES];
    acc_t integ_out  [STAGES];
    acc_t upsampled;
    acc_t scaled;

    always_comb begin
        tick   = out_ena && (phase_q == '0);
        accept = in_valid && in_ready_q;

        phase_d = phase_q;
        if (out_ena) phase_d = phase_q + 1'b1;

        // On an empty buffer the comb chain sees the previous sample again.
        eff_sample = buf_full_q ? buf_q : last_q;
        last_d     = tick ? eff_sample : last_q;

        buf_full_d = buf_full_q;
        if (tick)   buf_full_d = 1'b0;
        if (accept) buf_full_d = 1'b1;
        buf_d      = accept ? in_sample : buf_q;
        in_ready_d = !buf_full_d;
        underrun_d = underrun_q || (tick && !buf_full_q);

        comb_val[0] = acc_t'(eff_sample);
        for (int k = 0; k < STAGES; k++) begin
            comb_val[k+1] = comb_val[k] - comb_dly_q[k];
            comb_dly_d[k] = tick ? comb_val[k] : comb_dly_q[k];
        end
        upsampled = tick ? comb_val[STAGES] : '0;

        // Interpolator gain is R^(N-1); a pure shift removes it exactly.
        scaled      = integ_out[STAGES-1] >>> SHIFT;
        out_d       = out_ena ? f_format(f_round(scaled)) : out_q;
        out_valid_d = out_ena;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_integ
        if (k == 0) begin : g_first
            assign integ_in[k] = upsampled;
        end else begin : g_next
            assign integ_in[k] = integ_out[k-1];
        end

        cic_integrator_stage #(
            .ACC_W (ACC_W)
        ) u_integ (
            .clk     (clk),
            .rst     (rst),
            .ena     (out_ena),
            .acc_in  (integ_in[k]),
            .acc_out (integ_out[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            buf_full_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            underrun_q  <= 1'b0;
            out_valid_q <= 1'b0;
            buf_q       <= '0;
            last_q      <= '0;
            out_q       <= OUT_RST;
            for (int k = 0; k < STAGES; k++) comb_dly_q[k] <= '0;
        end else begin
            phase_q     <= phase_d;
            buf_full_q  <= buf_full_d;
            in_ready_q  <= in_ready_d;
            underrun_q  <= underrun_d;
            out_valid_q <= out_valid_d;
            buf_q       <= buf_d;
            last_q      <= last_d;
            out_q       <= out_d;
            for (int k = 0; k < STAGES; k++) comb_dly_q[k] <= comb_dly_d[k];
        end
    end

    assign in_ready   = in_ready_q;
    assign underrun   = underrun_q;
    assign out_sample = out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_cic_interp_n.sv
// Scoreboard bench for cic_interp_n: reference output is the zero-stuffed sample stream convolved with the CIC impulse response.
module tb_cic_interp_n;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 16;
    localparam int STAGES  = 3;
    localparam int RATE    = 4;
    localparam int LR      = 2;
    localparam int SHIFT   = (STAGES - 1) * LR;
    localparam int DROP    = IN_W - OUT_W;
    localparam int DROP_M1 = (DROP > 0) ? DROP - 1 : 0;

    localparam int M_DC   = 0;
    localparam int M_RAND = 1;
    localparam int M_ALT  = 2;
    localparam int M_IMP  = 3;
    localparam int M_RAMP = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             out_ena;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sample;
    logic [OUT_W-1:0] out_sample;
    logic             out_valid;
    logic             underrun;

    cic_interp_n #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .STAGES (STAGES),
        .RATE   (RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_ena    (out_ena),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    longint           h[$];
    longint           xs[$];
    logic [OUT_W-1:0] exp_q[$];
    bit               m_full, m_ready, m_underrun, m_in_rst, exp_vld, mon_en;
    longint           m_buf, m_last;
    int               m_phase;

    function automatic void build_h();
        longint tmp[$];
        longint acc;
        h = {64'sd1};
        for (int s = 0; s < STAGES; s++) begin
            tmp = {};
            for (int i = 0; i < h.size() + RATE - 1; i++) begin
                acc = 0;
                for (int j = 0; j < RATE; j++)
                    if (i - j >= 0 && i - j < h.size()) acc += h[i-j];
                tmp.push_back(acc);
            end
            h = tmp;
        end
    endfunction

    function automatic logic [OUT_W-1:0] code_of(input longint v);
        logic [OUT_W-1:0] r;
        r = v[OUT_W-1:0];
`ifdef CIC_UNSIGNED_OUT_EN
        r[OUT_W-1] = ~r[OUT_W-1];
`endif
        return r;
    endfunction

    // Output at strobe j reflects the high-rate input up to strobe j-STAGES.
    function automatic logic [OUT_W-1:0] model_out();
        longint y = 0;
        longint s;
        for (int m = 0; m < h.size(); m++)
            if (STAGES + m < xs.size()) y += h[m] * xs[STAGES+m];
        s = y >>> SHIFT;
        if (DROP > 0) begin
            s = (s + (64'sd1 <<< DROP_M1)) >>> DROP;
            if (s > (64'sd1 <<< (OUT_W - 1)) - 1) s = (64'sd1 <<< (OUT_W - 1)) - 1;
        end
        return code_of(s);
    endfunction

    always @(posedge clk) begin : model
        bit     acc_now;
        longint eff;
        exp_vld = 1'b0;
        if (rst) begin
            mon_en     = 1'b1;
            m_in_rst   = 1'b1;
            m_full     = 1'b0;
            m_ready    = 1'b0;
            m_underrun = 1'b0;
            m_buf      = 0;
            m_last     = 0;
            m_phase    = 0;
            xs         = {};
        end else begin
            m_in_rst = 1'b0;
            acc_now  = in_valid && m_ready;
            if (out_ena) begin
                if (m_phase == 0) begin
                    if (m_full) eff = m_buf;
                    else begin
                        eff        = m_last;
                        m_underrun = 1'b1;
                    end
                    m_last = eff;
                    m_full = 1'b0;
                    xs.push_front(eff);
                end else begin
                    xs.push_front(0);
                end
                if (xs.size() > STAGES + h.size() + 1) void'(xs.pop_back());
                exp_q.push_back(model_out());
                exp_vld = 1'b1;
                m_phase = (m_phase + 1) % RATE;
            end
            if (acc_now) begin
                m_full = 1'b1;
                m_buf  = longint'(signed'(in_sample));
            end
            m_ready = !m_full;
        end
    end

    logic [OUT_W-1:0] last_out;
    int               nz_cnt;

    always @(negedge clk) begin : monitor
        logic [OUT_W-1:0] e;
        if (mon_en) begin
            chk("out_valid", out_valid, exp_vld);
            if (out_valid || exp_vld) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard: output 0x%0h with no expected entry at %0t", out_sample, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (out_valid) begin
                        chk("out_sample", out_sample, e);
                        last_out = out_sample;
                        if (out_sample !== code_of(0)) nz_cnt++;
                    end
                end
            end
            chk("in_ready", in_ready, m_ready);
            chk("underrun", underrun, m_underrun);
            if (m_in_rst) chk("rst_out_sample", out_sample, code_of(0));
        end
    end

    // Stimulus
    int  cyc;
    bit  need_load;
    int  gen_cnt;
    int  cval;

    function automatic logic [IN_W-1:0] gen(input int mode);
        int v;
        case (mode)
            M_RAND:  v = int'($urandom_range(65535)) - 32768;
            M_ALT:   v = (gen_cnt % 2 == 0) ? -32768 : 32767;
            M_IMP:   v = (gen_cnt == 0) ? 1024 : 0;
            M_RAMP:  v = -20000 + gen_cnt * 1500;
            default: v = cval;
        endcase
        gen_cnt++;
        return v[IN_W-1:0];
    endfunction

    task automatic set_mode(input int val);
        gen_cnt   = 0;
        cval      = val;
        need_load = 1'b1;
    endtask

    task automatic run_clks(input int n, input int mode, input int vpct);
        bit rdy;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (need_load) begin
                in_sample = gen(mode);
                need_load = 1'b0;
            end
            in_valid = ($urandom_range(99) < vpct);
            out_ena  = (cyc % 4 == 0);
            cyc++;
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) need_load = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        out_ena  = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        rst       = 1'b0;
        cyc       = 1;
        need_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        chk("underrun_after_rst", underrun, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        build_h();
        rst       = 1'b1;
        out_ena   = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        cyc       = 0;
        nz_cnt    = 0;
        do_reset(3);

        set_mode(0);
        run_clks(3 * 16, M_DC, 100);
        chk("dc0_final", last_out, code_of(0));

        set_mode(1000);
        run_clks(6 * 16, M_DC, 100);
        chk("dc1000_final", last_out, code_of(1000));
        chk("dc1000_no_underrun", underrun, 0);

        set_mode(4096);
        run_clks(6 * 16, M_DC, 100);
        chk("step_final", last_out, code_of(4096));

        do_reset(2);
        nz_cnt = 0;
        set_mode(0);
        run_clks(6 * 16, M_IMP, 100);
        chk("impulse_nonzero_count", nz_cnt, 10);
        chk("impulse_final", last_out, code_of(0));

        set_mode(0);
        run_clks(10 * 16, M_RAND, 100);

        set_mode(0);
        run_clks(10 * 16, M_ALT, 100);

        set_mode(777);
        run_clks(2 * 16, M_DC, 0);
        chk("underrun_set", underrun, 1);

        set_mode(0);
        run_clks(8 * 16, M_RAND, 60);
        chk("underrun_sticky", underrun, 1);

        set_mode(0);
        run_clks(3 * 16 + int'($urandom_range(15, 1)), M_RAMP, 100);
        do_reset(2);

        set_mode(-5000);
        run_clks(6 * 16, M_DC, 100);
        chk("dc_neg_final", last_out, code_of(-5000));

        @(negedge clk);
        out_ena  = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
